// File: rtl/load_store_unit_if.sv
// Data-memory handshake bundle between the load/store unit (master) and a
// variable-latency data memory (slave).
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Sequential load/store unit: captures one core load/store, issues a single
// word-aligned memory transaction with byte enables, formats load data and
// stalls the core until completion.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses raise lsu_err instead of being truncated to the natural
// boundary.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_funct3,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_stall,
    output logic              lsu_done,
    output logic [31:0]       lsu_rdata,
    output logic              lsu_err,
    load_store_unit_if.master mem
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              mem_req_r;
    logic              done_r;
    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        funct3_r;
    logic              we_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata_r;
    logic              err_r;
    logic              err_s;
    logic [ADDR_W-1:0] addr_eff_s;

    // Stores only allow sb/sh/sw; loads reject the three unused encodings.
    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        if (we) begin
            bad = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
        end else begin
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return bad;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = a[0];
            2'b10:   bad = (a != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Clear the low address bits below the access size's natural boundary.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [2:0] f3, input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = a;
        case (f3[1:0])
            2'b01:   r[0]   = 1'b0;
            2'b10:   r[1:0] = 2'b00;
            default: r      = a;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the store operand across lanes so the byte enables pick it up.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    assign err_s      = funct3_illegal(lsu_we, lsu_funct3) |
                        (TRAP_EN & misaligned(lsu_funct3, lsu_addr[1:0]));
    assign addr_eff_s = align_addr(lsu_funct3, lsu_addr);

    // State register plus request/done strobes registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            mem_req_r <= (state_s == ST_REQ);
            done_r    <= (state_s == ST_DONE);
        end
    end

    // Next-state logic: handshake stalls in REQ/WAIT, errors bypass memory.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (lsu_req) begin
                    if (err_s) state_s = ST_DONE;
                    else       state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem.mem_gnt) begin
                    if (we_r) state_s = ST_DONE;
                    else      state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rvalid) state_s = ST_DONE;
                else                state_s = ST_WAIT;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Capture the request in IDLE and register formatted load data in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r   <= '0;
            funct3_r <= 3'b000;
            we_r     <= 1'b0;
            be_r     <= 4'b0000;
            wdata_r  <= 32'h0000_0000;
            rdata_r  <= 32'h0000_0000;
            err_r    <= 1'b0;
        end else if ((state_r == ST_IDLE) && lsu_req) begin
            addr_r   <= addr_eff_s;
            funct3_r <= lsu_funct3;
            we_r     <= lsu_we;
            be_r     <= byte_en(lsu_funct3, addr_eff_s[1:0]);
            wdata_r  <= lane_wdata(lsu_funct3, lsu_wdata);
            err_r    <= err_s;
            if (err_s) rdata_r <= 32'h0000_0000;
            else       rdata_r <= rdata_r;
        end else if ((state_r == ST_WAIT) && mem.mem_rvalid) begin
            rdata_r <= load_format(funct3_r, addr_r[1:0], mem.mem_rdata);
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = we_r;
    assign mem.mem_addr  = {addr_r[ADDR_W-1:2], 2'b00};
    assign mem.mem_be    = be_r;
    assign mem.mem_wdata = wdata_r;

    assign lsu_done  = done_r;
    assign lsu_rdata = rdata_r;
    assign lsu_err   = err_r;
    assign lsu_stall = lsu_req & ~done_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small handshaked
// memory responder (programmable gnt / rvalid delay).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;

    int checks   = 0;
    int failures = 0;

    int          r_done_cyc;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_saw_req;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_stable;
    logic        r_stall_ok;

    load_store_unit_if #(.ADDR_W(32)) mem_bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .lsu_req    (lsu_req),
        .lsu_we     (lsu_we),
        .lsu_funct3 (lsu_funct3),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_stall  (lsu_stall),
        .lsu_done   (lsu_done),
        .lsu_rdata  (lsu_rdata),
        .lsu_err    (lsu_err),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Run one request; cycle 1 is the IDLE cycle in which lsu_req is first seen.
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rword);
        int   cyc;
        int   req_cnt;
        int   rv_k;
        logic rv_armed;
        logic done;
        r_done_cyc = 0;   r_rdata = 32'h0;  r_err = 1'b0;   r_saw_req = 1'b0;
        r_addr = 32'h0;   r_be = 4'h0;      r_wdata = 32'h0; r_we = 1'b0;
        r_stable = 1'b1;  r_stall_ok = 1'b1;
        cyc = 0; req_cnt = 0; rv_k = 0; rv_armed = 1'b0; done = 1'b0;
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
        while (!done && cyc < 40) begin
            cyc++;
            @(negedge clk);
            if (lsu_done === 1'b1) begin
                done       = 1'b1;
                r_done_cyc = cyc;
                r_rdata    = lsu_rdata;
                r_err      = lsu_err;
                if (lsu_stall !== 1'b0) r_stall_ok = 1'b0;
                lsu_req            = 1'b0;
                mem_bus.mem_gnt    = 1'b0;
                mem_bus.mem_rvalid = 1'b0;
            end else begin
                if (lsu_stall !== 1'b1) r_stall_ok = 1'b0;
                mem_bus.mem_rvalid = 1'b0;
                mem_bus.mem_rdata  = 32'h5A5A_5A5A;
                if (rv_armed) begin
                    if (rv_k == rv_dly) begin
                        mem_bus.mem_rvalid = 1'b1;
                        mem_bus.mem_rdata  = rword;
                        rv_armed           = 1'b0;
                    end
                    rv_k++;
                end
                mem_bus.mem_gnt = 1'b0;
                if (mem_bus.mem_req === 1'b1) begin
                    if (!r_saw_req) begin
                        r_saw_req = 1'b1;
                        r_addr    = mem_bus.mem_addr;
                        r_be      = mem_bus.mem_be;
                        r_wdata   = mem_bus.mem_wdata;
                        r_we      = mem_bus.mem_we;
                    end else if ((mem_bus.mem_addr !== r_addr) || (mem_bus.mem_be !== r_be) ||
                                 (mem_bus.mem_wdata !== r_wdata) || (mem_bus.mem_we !== r_we)) begin
                        r_stable = 1'b0;
                    end
                    if (req_cnt == gnt_dly) begin
                        mem_bus.mem_gnt = 1'b1;
                        if (!we) begin
                            rv_armed = 1'b1;
                            rv_k     = 0;
                        end
                    end
                    req_cnt++;
                end
            end
        end
        lsu_req            = 1'b0;
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        logic seen_done;
        logic seen_req;
        rst = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b000;
        lsu_addr = 32'h0; lsu_wdata = 32'h0;
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
        #2 rst = 1'b0;
        #1;
        check_val("reset_mem_req",   {31'h0, mem_bus.mem_req}, 32'h0);
        check_val("reset_mem_addr",  mem_bus.mem_addr, 32'h0);
        check_val("reset_mem_be",    {28'h0, mem_bus.mem_be}, 32'h0);
        check_val("reset_mem_wdata", mem_bus.mem_wdata, 32'h0);
        check_val("reset_done",      {31'h0, lsu_done}, 32'h0);
        check_val("reset_rdata",     lsu_rdata, 32'h0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;

        // sw 0x104, zero-wait memory
        do_op(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 32'h0);
        check_val("sw_addr",  r_addr, 32'h0000_0104);
        check_val("sw_be",    {28'h0, r_be}, 32'h0000_000F);
        check_val("sw_wdata", r_wdata, 32'hDEAD_BEEF);
        check_val("sw_we",    {31'h0, r_we}, 32'h1);
        check_val("sw_lat",   r_done_cyc, 32'd3);
        check_val("sw_err",   {31'h0, r_err}, 32'h0);

        // lb / lbu on top byte lane
        do_op(1'b0, 3'b000, 32'h0000_0203, 32'h0, 0, 0, 32'h80FF_1234);
        check_val("lb_be",    {28'h0, r_be}, 32'h0000_0008);
        check_val("lb_addr",  r_addr, 32'h0000_0200);
        check_val("lb_rdata", r_rdata, 32'hFFFF_FF80);
        check_val("lb_lat",   r_done_cyc, 32'd4);
        do_op(1'b0, 3'b100, 32'h0000_0203, 32'h0, 0, 0, 32'h80FF_1234);
        check_val("lbu_rdata", r_rdata, 32'h0000_0080);

        // sh / lhu / lh on upper half
        do_op(1'b1, 3'b001, 32'h0000_0032, 32'h0000_ABCD, 0, 0, 32'h0);
        check_val("sh_be",    {28'h0, r_be}, 32'h0000_000C);
        check_val("sh_wdata", r_wdata, 32'hABCD_ABCD);
        check_val("sh_addr",  r_addr, 32'h0000_0030);
        do_op(1'b0, 3'b101, 32'h0000_0032, 32'h0, 0, 0, 32'hABCD_0000);
        check_val("lhu_rdata", r_rdata, 32'h0000_ABCD);
        do_op(1'b0, 3'b001, 32'h0000_0032, 32'h0, 0, 0, 32'hABCD_0000);
        check_val("lh_rdata", r_rdata, 32'hFFFF_ABCD);

        // sb on lane 1
        do_op(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 0, 0, 32'h0);
        check_val("sb_be",    {28'h0, r_be}, 32'h0000_0002);
        check_val("sb_wdata", r_wdata, 32'hA5A5_A5A5);

        // misaligned lw 0x101
        do_op(1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 0, 32'h1234_5678);
`ifdef LSU_MISALIGN_TRAP_EN
        check_val("mis_no_req", {31'h0, r_saw_req}, 32'h0);
        check_val("mis_err",    {31'h0, r_err}, 32'h1);
        check_val("mis_rdata",  r_rdata, 32'h0);
        check_val("mis_lat",    r_done_cyc, 32'd2);
`else
        check_val("mis_addr",  r_addr, 32'h0000_0100);
        check_val("mis_err",   {31'h0, r_err}, 32'h0);
        check_val("mis_rdata", r_rdata, 32'h1234_5678);
        check_val("mis_lat",   r_done_cyc, 32'd4);
`endif

        // illegal funct3 for load and store
        do_op(1'b0, 3'b011, 32'h0000_0000, 32'h0, 0, 0, 32'h0);
        check_val("ill_ld_err",    {31'h0, r_err}, 32'h1);
        check_val("ill_ld_no_req", {31'h0, r_saw_req}, 32'h0);
        check_val("ill_ld_lat",    r_done_cyc, 32'd2);
        check_val("ill_ld_rdata",  r_rdata, 32'h0);
        do_op(1'b1, 3'b100, 32'h0000_0000, 32'h0, 0, 0, 32'h0);
        check_val("ill_st_err", {31'h0, r_err}, 32'h1);

        // slow memory: gnt 3 cycles late, rvalid 2 cycles late
        do_op(1'b0, 3'b010, 32'h0000_0080, 32'h0, 3, 2, 32'hCAFE_F00D);
        check_val("slow_lat",    r_done_cyc, 32'd9);
        check_val("slow_stall",  {31'h0, r_stall_ok}, 32'h1);
        check_val("slow_stable", {31'h0, r_stable}, 32'h1);
        check_val("slow_rdata",  r_rdata, 32'hCAFE_F00D);

        // reset while in WAIT, then a late rvalid
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h0000_0040;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_in_req", {31'h0, mem_bus.mem_req}, 32'h1);
        mem_bus.mem_gnt = 1'b1;
        @(posedge clk); #1 mem_bus.mem_gnt = 1'b0;
        @(negedge clk);
        rst = 1'b0; lsu_req = 1'b0;
        #1;
        check_val("rst_mem_req",   {31'h0, mem_bus.mem_req}, 32'h0);
        check_val("rst_mem_addr",  mem_bus.mem_addr, 32'h0);
        check_val("rst_mem_be",    {28'h0, mem_bus.mem_be}, 32'h0);
        check_val("rst_mem_wdata", mem_bus.mem_wdata, 32'h0);
        check_val("rst_rdata",     lsu_rdata, 32'h0);
        check_val("rst_err",       {31'h0, lsu_err}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h1122_3344;
        seen_done = 1'b0; seen_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_bus.mem_rvalid = 1'b0;
            if (lsu_done === 1'b1)        seen_done = 1'b1;
            if (mem_bus.mem_req === 1'b1) seen_req  = 1'b1;
        end
        check_val("late_rv_no_done", {31'h0, seen_done}, 32'h0);
        check_val("late_rv_no_req",  {31'h0, seen_req}, 32'h0);
        check_val("late_rv_rdata",   lsu_rdata, 32'h0);

        // FSM back in IDLE: a fresh lbu completes with nominal latency
        do_op(1'b0, 3'b100, 32'h0000_0002, 32'h0, 0, 0, 32'h00C3_0000);
        check_val("post_rst_lat",   r_done_cyc, 32'd4);
        check_val("post_rst_rdata", r_rdata, 32'h0000_00C3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store unit between the single-cycle core's execute stage and a handshaked data memory. It takes the core's effective address, store data and funct3, and issues one word-aligned memory transaction with byte enables. It formats load data (lb/lh/lw/lbu/lhu) and stalls the core until the access completes. It replaces the core's direct combinational data-memory connection so that memories with variable latency can be used.

## Interface

Parameters:
- `ADDR_W`, 32: core and memory address width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `lsu_req`  in  1  core has a load/store in execute; held with all fields stable while `lsu_stall`=1.
- `lsu_we`  in  1  1 = store, 0 = load.
- `lsu_funct3`  in  3  RV32I load/store funct3.
- `lsu_addr`  in  ADDR_W  effective byte address (rs1+imm).
- `lsu_wdata`  in  32  store data (rs2).
- `lsu_stall`  out  1  freeze core PC/regfile write; combinational, equals `lsu_req & ~lsu_done`.
- `lsu_done`  out  1  one-cycle completion pulse.
- `lsu_rdata`  out  32  formatted load result; valid while `lsu_done`=1.
- `lsu_err`  out  1  misaligned access or illegal funct3; valid with `lsu_done`.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  ADDR_W  word address, bits [1:0] = 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`  in  1  request accepted; may be high in the same cycle `mem_req` rises.
- `mem_rvalid`  in  1  load data valid; arrives at least 1 cycle after `mem_gnt`.
- `mem_rdata`  in  32  load word.

## Operation

- The FSM has four states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - With `lsu_req`=1, the request is checked and captured (addr, funct3, we, wdata) into registers.
  - An error goes to DONE with the error flag set.
  - Otherwise the FSM goes to REQ.
- REQ:
  - `mem_req`=1; all memory outputs come from the captured registers and stay stable.
  - On `mem_gnt`, a store goes to DONE and a load goes to WAIT.
- WAIT:
  - On `mem_rvalid`, the formatted data is registered into `lsu_rdata` and the FSM goes to DONE.
- DONE:
  - `lsu_done`=1 for exactly one cycle, then the FSM returns to IDLE.
  - A `lsu_req` seen in the following IDLE is treated as a new instruction.
- Errors:
  - halfword (001/101) access with addr[0]=1;
  - word (010) access with addr[1:0]≠0;
  - funct3 011/110/111 for a load, or anything other than 000/001/010 for a store.
- Byte enables:
  - sb: `1<<addr[1:0]`, store byte replicated to all 4 lanes;
  - sh: 0011 or 1100 selected by addr[1], store half replicated to both halves;
  - sw: 1111.
- Load format: select the lane by the captured addr[1:0], then sign-extend (lb, lh) or zero-extend (lbu, lhu); lw passes the word through.
- `lsu_rdata` holds its last value until the next `mem_rvalid`. On an error it is forced to 0.
- `mem_rvalid` outside WAIT is ignored. `mem_gnt` outside REQ is ignored.
- If the core drops `lsu_req` after capture (a protocol violation), the transaction still completes and `lsu_done` still pulses.

## Timing

- Reset values: state IDLE; `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `lsu_rdata`, `lsu_done`, `lsu_err` all 0.
- Reset asserted mid-transaction aborts it immediately. A late `mem_rvalid` after release is ignored, since the FSM is in IDLE.
- Latency with a zero-wait memory (gnt in the REQ cycle, rvalid one cycle later), counted from the cycle `lsu_req` is first seen:
  - load: 4 cycles to `lsu_done` (IDLE, REQ, WAIT, DONE);
  - store: 3 cycles;
  - error: 2 cycles.
- Each memory wait cycle (gnt or rvalid late) adds exactly one cycle.
- At most one outstanding transaction; no new request is accepted until DONE completes.

## Configuration

- `LSU_MISALIGN_TRAP_EN` defined:
  - misaligned accesses raise `lsu_err` and issue no memory transaction, as described above.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - alignment is not checked; the address is truncated to the natural boundary (addr[0] cleared for half, addr[1:0] cleared for word) and the access proceeds normally;
  - `lsu_err` is raised only for illegal funct3.

## Test plan

- sw addr 0x104, data 0xDEADBEEF, gnt same cycle -> `mem_addr`=0x104, `mem_be`=1111, `lsu_done` 3 cycles after request, `lsu_err`=0.
- lb addr 0x203, `mem_rdata`=0x80FF_1234 -> `mem_be`=1000, `lsu_rdata`=0xFFFFFF80; repeat as lbu -> 0x00000080.
- sh addr 0x32, data 0x0000ABCD -> `mem_be`=1100, `mem_wdata`=0xABCDABCD; lhu addr 0x32 on 0xABCD0000 -> 0x0000ABCD.
- lw addr 0x101 with the macro defined -> no `mem_req`, `lsu_err`=1, `lsu_rdata`=0, done in 2 cycles; without the macro -> `mem_addr`=0x100, `lsu_err`=0.
- Load with gnt delayed 3 cycles and rvalid delayed 2 -> `lsu_stall` high throughout, done at cycle 9, `mem_*` outputs stable while in REQ.
- `rst` pulled low in WAIT, then `mem_rvalid` after release -> all outputs 0, FSM in IDLE, response ignored, no `lsu_done`.
